// File: rtl/axi_config_arb.sv
// Two-port round-robin arbiter in front of one single-port register target.
// Optional sticky error port: define AXI_CONFIG_ARB_ERR_EN.
module axi_config_arb #(
  parameter int ADDR_WIDTH         = 32,
  parameter int DATA_WIDTH         = 32,
  parameter int STRB_WIDTH         = DATA_WIDTH / 8,
  parameter int FIFO_DEPTH         = 4,
  parameter int MAX_RD_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s0_rd,
  input  logic [ADDR_WIDTH-1:0] s0_raddr,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  output logic                  s0_rvalid,
  input  logic                  s0_wr,
  input  logic [ADDR_WIDTH-1:0] s0_waddr,
  input  logic [DATA_WIDTH-1:0] s0_wdata,
  input  logic [STRB_WIDTH-1:0] s0_wstrb,
  output logic                  s0_full,
  input  logic                  s1_rd,
  input  logic [ADDR_WIDTH-1:0] s1_raddr,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  output logic                  s1_rvalid,
  input  logic                  s1_wr,
  input  logic [ADDR_WIDTH-1:0] s1_waddr,
  input  logic [DATA_WIDTH-1:0] s1_wdata,
  input  logic [STRB_WIDTH-1:0] s1_wstrb,
  output logic                  s1_full,
  output logic                  m_rd,
  output logic [ADDR_WIDTH-1:0] m_raddr,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_rvalid,
  output logic                  m_wr,
  output logic [ADDR_WIDTH-1:0] m_waddr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [STRB_WIDTH-1:0] m_wstrb
`ifdef AXI_CONFIG_ARB_ERR_EN
  ,
  output logic [1:0]            err
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (MAX_RD_OUTSTANDING > 1) ? $clog2(MAX_RD_OUTSTANDING) : 1;
  localparam int TD = 1 << TW;
  localparam int OW = $clog2(MAX_RD_OUTSTANDING) + 1;

  typedef struct packed {
    logic                  is_wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;
  } entry_t;

  logic [1:0]            rd_s;
  logic [1:0]            wr_s;
  logic [ADDR_WIDTH-1:0] raddr_s [2];
  logic [ADDR_WIDTH-1:0] waddr_s [2];
  logic [DATA_WIDTH-1:0] wdata_s [2];
  logic [STRB_WIDTH-1:0] wstrb_s [2];
  entry_t                head_s  [2];
  logic [1:0]            valid_s;
  logic [1:0]            elig_s;
  logic [1:0]            pop_s;
  logic [1:0]            full_s;
  logic                  rd_room_s;
  logic                  gnt_valid_s;
  logic                  gnt_id_s;
  entry_t                gnt_ent_s;
  logic                  issue_rd_s;
  logic                  issue_wr_s;
  logic                  ret_s;
  logic                  tag_head_s;
  logic                  last_r;
  logic                  tag_mem_r [TD];
  logic [TW-1:0]         tag_wptr_r;
  logic [TW-1:0]         tag_rptr_r;
  logic [OW-1:0]         out_cnt_r;

  assign rd_s       = {s1_rd, s0_rd};
  assign wr_s       = {s1_wr, s0_wr};
  assign raddr_s[0] = s0_raddr;
  assign raddr_s[1] = s1_raddr;
  assign waddr_s[0] = s0_waddr;
  assign waddr_s[1] = s1_waddr;
  assign wdata_s[0] = s0_wdata;
  assign wdata_s[1] = s1_wdata;
  assign wstrb_s[0] = s0_wstrb;
  assign wstrb_s[1] = s1_wstrb;
  assign s0_full    = full_s[0];
  assign s1_full    = full_s[1];
  assign rd_room_s  = (out_cnt_r < OW'(MAX_RD_OUTSTANDING));

  // The head bypasses an empty FIFO so an uncontended request issues the same cycle.
  for (genvar p = 0; p < 2; p++) begin : g_port
    entry_t        mem_r [FIFO_DEPTH];
    logic [PW-1:0] wptr_r;
    logic [PW-1:0] rptr_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          full_r;
    logic [1:0]    in_cnt_s;
    entry_t        wr_ent_s;
    entry_t        rd_ent_s;

    assign wr_ent_s  = '{is_wr: 1'b1, addr: waddr_s[p], data: wdata_s[p], strb: wstrb_s[p]};
    assign rd_ent_s  = '{is_wr: 1'b0, addr: raddr_s[p], data: '0, strb: '0};
    assign in_cnt_s  = full_r ? 2'd0 : ({1'b0, wr_s[p]} + {1'b0, rd_s[p]});
    assign cnt_nxt_s = cnt_r + CW'(in_cnt_s) - CW'(pop_s[p]);
    assign head_s[p] = (cnt_r != '0) ? mem_r[rptr_r] : (wr_s[p] ? wr_ent_s : rd_ent_s);
    assign valid_s[p] = (cnt_r != '0) || (in_cnt_s != 2'd0);
    assign elig_s[p]  = valid_s[p] && (head_s[p].is_wr || rd_room_s);
    assign full_s[p]  = full_r;

    // Command FIFO: write lands before read; a bypassed entry is skipped by the read pointer.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        wptr_r <= '0;
        rptr_r <= '0;
        cnt_r  <= '0;
        full_r <= 1'b0;
      end else begin
        if (in_cnt_s == 2'd2) begin
          mem_r[wptr_r]                <= wr_ent_s;
          mem_r[wptr_r + PW'(1'b1)]    <= rd_ent_s;
        end else if (in_cnt_s == 2'd1) begin
          mem_r[wptr_r] <= wr_s[p] ? wr_ent_s : rd_ent_s;
        end
        wptr_r <= wptr_r + PW'(in_cnt_s);
        rptr_r <= rptr_r + PW'(pop_s[p]);
        cnt_r  <= cnt_nxt_s;
        full_r <= (cnt_nxt_s > CW'(FIFO_DEPTH - 2));
      end
    end
  end

  // Round-robin grant; last_r names the port served most recently.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_id_s    = 1'b0;
    case (elig_s)
      2'b01: begin
        gnt_valid_s = 1'b1;
        gnt_id_s    = 1'b0;
      end
      2'b10: begin
        gnt_valid_s = 1'b1;
        gnt_id_s    = 1'b1;
      end
      2'b11: begin
        gnt_valid_s = 1'b1;
        gnt_id_s    = ~last_r;
      end
      default: begin
        gnt_valid_s = 1'b0;
        gnt_id_s    = 1'b0;
      end
    endcase
  end

  assign pop_s      = gnt_valid_s ? (gnt_id_s ? 2'b10 : 2'b01) : 2'b00;
  assign gnt_ent_s  = head_s[gnt_id_s];
  assign issue_rd_s = gnt_valid_s && !gnt_ent_s.is_wr;
  assign issue_wr_s = gnt_valid_s && gnt_ent_s.is_wr;
  assign ret_s      = m_rvalid && (out_cnt_r != '0);
  assign tag_head_s = tag_mem_r[tag_rptr_r];

  // Issue register, read-tag FIFO and response steering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_rd       <= 1'b0;
      m_wr       <= 1'b0;
      m_raddr    <= '0;
      m_waddr    <= '0;
      m_wdata    <= '0;
      m_wstrb    <= '0;
      last_r     <= 1'b1;
      tag_wptr_r <= '0;
      tag_rptr_r <= '0;
      out_cnt_r  <= '0;
      s0_rvalid  <= 1'b0;
      s1_rvalid  <= 1'b0;
      s0_rdata   <= '0;
      s1_rdata   <= '0;
    end else begin
      m_rd <= issue_rd_s;
      m_wr <= issue_wr_s;
      if (issue_rd_s) begin
        m_raddr                <= gnt_ent_s.addr;
        tag_mem_r[tag_wptr_r]  <= gnt_id_s;
        tag_wptr_r             <= tag_wptr_r + TW'(1'b1);
      end
      if (issue_wr_s) begin
        m_waddr <= gnt_ent_s.addr;
        m_wdata <= gnt_ent_s.data;
        m_wstrb <= gnt_ent_s.strb;
      end
      if (gnt_valid_s) begin
        last_r <= gnt_id_s;
      end
      if (ret_s) begin
        tag_rptr_r <= tag_rptr_r + TW'(1'b1);
      end
      out_cnt_r <= out_cnt_r + OW'(issue_rd_s) - OW'(ret_s);
      s0_rvalid <= ret_s && !tag_head_s;
      s1_rvalid <= ret_s && tag_head_s;
      if (ret_s && !tag_head_s) begin
        s0_rdata <= m_rdata;
      end
      if (ret_s && tag_head_s) begin
        s1_rdata <= m_rdata;
      end
    end
  end

`ifdef AXI_CONFIG_ARB_ERR_EN
  logic drop_s;
  logic orphan_s;

  assign drop_s   = |((rd_s | wr_s) & full_s);
  assign orphan_s = m_rvalid && (out_cnt_r == '0);

  // Sticky error flags: bit 0 dropped request, bit 1 orphan response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 2'b00;
    end else begin
      err <= err | {orphan_s, drop_s};
    end
  end
`endif

endmodule

// File: tb/tb_axi_config_arb.sv
// Scoreboard bench for axi_config_arb: expected commands/responses queued by stimulus, checked by a monitor.
module tb_axi_config_arb;

  typedef struct packed {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } cmd_t;

  logic        clk;
  logic        rst_n;
  logic        s0_rd, s0_wr, s1_rd, s1_wr;
  logic [31:0] s0_raddr, s0_waddr, s0_wdata, s1_raddr, s1_waddr, s1_wdata;
  logic [3:0]  s0_wstrb, s1_wstrb;
  logic [31:0] s0_rdata, s1_rdata;
  logic        s0_rvalid, s1_rvalid, s0_full, s1_full;
  logic        m_rd, m_wr, m_rvalid;
  logic [31:0] m_raddr, m_rdata, m_waddr, m_wdata;
  logic [3:0]  m_wstrb;
`ifdef AXI_CONFIG_ARB_ERR_EN
  logic [1:0]  err;
`endif

  int   n_pass = 0;
  int   n_total = 0;
  int   rd_pulses = 0;
  int   base;
  cmd_t exp_cmd[$];
  logic [31:0] exp_r0[$];
  logic [31:0] exp_r1[$];
  cmd_t mon_e;

  axi_config_arb dut (
    .clk(clk), .rst_n(rst_n),
    .s0_rd(s0_rd), .s0_raddr(s0_raddr), .s0_rdata(s0_rdata), .s0_rvalid(s0_rvalid),
    .s0_wr(s0_wr), .s0_waddr(s0_waddr), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_full(s0_full),
    .s1_rd(s1_rd), .s1_raddr(s1_raddr), .s1_rdata(s1_rdata), .s1_rvalid(s1_rvalid),
    .s1_wr(s1_wr), .s1_waddr(s1_waddr), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_full(s1_full),
`ifdef AXI_CONFIG_ARB_ERR_EN
    .err(err),
`endif
    .m_rd(m_rd), .m_raddr(m_raddr), .m_rdata(m_rdata), .m_rvalid(m_rvalid),
    .m_wr(m_wr), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    s0_rd = 1'b0; s0_wr = 1'b0; s1_rd = 1'b0; s1_wr = 1'b0; m_rvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic exp_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_cmd.push_back('{is_wr: 1'b1, addr: a, data: d, strb: s});
  endtask

  task automatic exp_rd(input logic [31:0] a);
    exp_cmd.push_back('{is_wr: 1'b0, addr: a, data: 32'h0, strb: 4'h0});
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_m_rd"},      64'(m_rd), 64'd0);
    chk({tag, "_m_wr"},      64'(m_wr), 64'd0);
    chk({tag, "_m_raddr"},   64'(m_raddr), 64'd0);
    chk({tag, "_m_waddr"},   64'(m_waddr), 64'd0);
    chk({tag, "_m_wdata"},   64'(m_wdata), 64'd0);
    chk({tag, "_m_wstrb"},   64'(m_wstrb), 64'd0);
    chk({tag, "_s0_rdata"},  64'(s0_rdata), 64'd0);
    chk({tag, "_s1_rdata"},  64'(s1_rdata), 64'd0);
    chk({tag, "_rvalid"},    64'({s1_rvalid, s0_rvalid}), 64'd0);
    chk({tag, "_full"},      64'({s1_full, s0_full}), 64'd0);
`ifdef AXI_CONFIG_ARB_ERR_EN
    chk({tag, "_err"},       64'(err), 64'd0);
`endif
  endtask

  // Monitor: compares every target command and every port response against the queues.
  always @(negedge clk) begin
    if (m_rd || m_wr) begin
      if (m_rd) rd_pulses++;
      chk("cmd_mutex", 64'(m_rd & m_wr), 64'd0);
      chk("cmd_expected", 64'(exp_cmd.size() != 0), 64'd1);
      if (exp_cmd.size() != 0) begin
        mon_e = exp_cmd.pop_front();
        chk("cmd_is_wr", 64'(m_wr), 64'(mon_e.is_wr));
        if (m_wr) begin
          chk("m_waddr", 64'(m_waddr), 64'(mon_e.addr));
          chk("m_wdata", 64'(m_wdata), 64'(mon_e.data));
          chk("m_wstrb", 64'(m_wstrb), 64'(mon_e.strb));
        end else begin
          chk("m_raddr", 64'(m_raddr), 64'(mon_e.addr));
        end
      end
    end
    if (s0_rvalid) begin
      chk("s0_rvalid_expected", 64'(exp_r0.size() != 0), 64'd1);
      if (exp_r0.size() != 0) chk("s0_rdata", 64'(s0_rdata), 64'(exp_r0.pop_front()));
    end
    if (s1_rvalid) begin
      chk("s1_rvalid_expected", 64'(exp_r1.size() != 0), 64'd1);
      if (exp_r1.size() != 0) chk("s1_rdata", 64'(s1_rdata), 64'(exp_r1.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    s0_rd = 1'b0; s0_wr = 1'b0; s1_rd = 1'b0; s1_wr = 1'b0; m_rvalid = 1'b0;
    s0_raddr = 32'h0; s0_waddr = 32'h0; s0_wdata = 32'h0; s0_wstrb = 4'h0;
    s1_raddr = 32'h0; s1_waddr = 32'h0; s1_wdata = 32'h0; s1_wstrb = 4'h0;
    m_rdata = 32'h0;
    idle(3);
    chk_reset_state("reset");
    rst_n = 1'b1;

    // Single uncontended write: visible on m_* exactly one cycle.
    idle(4);
    s0_wr = 1'b1; s0_waddr = 32'h10; s0_wdata = 32'hDEADBEEF; s0_wstrb = 4'hF;
    exp_w(32'h10, 32'hDEADBEEF, 4'hF);
    cyc();
    chk("t1_m_wr", 64'(m_wr), 64'd1);
    chk("t1_m_waddr", 64'(m_waddr), 64'h10);
    chk("t1_m_wdata", 64'(m_wdata), 64'hDEADBEEF);
    cyc();
    chk("t1_m_wr_once", 64'(m_wr), 64'd0);

    // Reset restores port 0 priority; simultaneous reads, in-order returns.
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    s0_rd = 1'b1; s0_raddr = 32'h20; s1_rd = 1'b1; s1_raddr = 32'h24;
    exp_rd(32'h20); exp_rd(32'h24);
    exp_r0.push_back(32'h11); exp_r1.push_back(32'h22);
    cyc();
    chk("t2_first_rd", 64'({m_rd, m_raddr}), {31'd0, 1'b1, 32'h20});
    cyc();
    chk("t2_second_rd", 64'({m_rd, m_raddr}), {31'd0, 1'b1, 32'h24});
    m_rvalid = 1'b1; m_rdata = 32'h11;
    cyc();
    chk("t2_s0_rvalid", 64'({s1_rvalid, s0_rvalid}), 64'b01);
    m_rvalid = 1'b1; m_rdata = 32'h22;
    cyc();
    chk("t2_s1_rvalid", 64'({s1_rvalid, s0_rvalid}), 64'b10);
    chk("t2_s0_rdata_hold", 64'(s0_rdata), 64'h11);
    idle(2);

    // Both ports loaded with writes: alternating grants, one write per cycle.
    for (int i = 0; i < 4; i++) begin
      exp_w(32'h40 + 32'(i * 4), 32'hA000 + 32'(i), 4'hF);
      exp_w(32'h80 + 32'(i * 4), 32'hB000 + 32'(i), 4'h3);
    end
    for (int i = 0; i < 4; i++) begin
      s0_wr = 1'b1; s0_waddr = 32'h40 + 32'(i * 4); s0_wdata = 32'hA000 + 32'(i); s0_wstrb = 4'hF;
      s1_wr = 1'b1; s1_waddr = 32'h80 + 32'(i * 4); s1_wdata = 32'hB000 + 32'(i); s1_wstrb = 4'h3;
      cyc();
      chk("t3_m_wr_busy", 64'(m_wr), 64'd1);
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t3_m_wr_busy", 64'(m_wr), 64'd1);
    end
    cyc();
    chk("t3_m_wr_done", 64'(m_wr), 64'd0);
    idle(1);

    // Five port-0 reads against a silent target: fourth limit, port 1 write still flows.
    base = rd_pulses;
    for (int i = 0; i < 4; i++) exp_rd(32'h100 + 32'(i * 4));
    exp_w(32'h200, 32'h12345678, 4'hF);
    exp_rd(32'h110);
    for (int i = 0; i < 5; i++) begin
      s0_rd = 1'b1; s0_raddr = 32'h100 + 32'(i * 4);
      cyc();
    end
    s1_wr = 1'b1; s1_waddr = 32'h200; s1_wdata = 32'h12345678; s1_wstrb = 4'hF;
    cyc();
    chk("t4_p1_write", 64'({m_wr, m_waddr}), {31'd0, 1'b1, 32'h200});
    idle(3);
    chk("t4_rd_limit", 64'(rd_pulses - base), 64'd4);
    for (int i = 0; i < 5; i++) exp_r0.push_back(32'hB0 + 32'(i));
    m_rvalid = 1'b1; m_rdata = 32'hB0;
    cyc();
    chk("t4_no_early_rd", 64'(m_rd), 64'd0);
    cyc();
    chk("t4_fifth_rd", 64'({m_rd, m_raddr}), {31'd0, 1'b1, 32'h110});
    for (int i = 1; i < 5; i++) begin
      m_rvalid = 1'b1; m_rdata = 32'hB0 + 32'(i);
      cyc();
    end
    idle(2);
    chk("t4_rd_total", 64'(rd_pulses - base), 64'd5);

    // Port 1 queue behind a blocked read: full at three entries, fourth request dropped.
    for (int i = 0; i < 4; i++) begin
      exp_rd(32'h400 + 32'(i * 4));
      s0_rd = 1'b1; s0_raddr = 32'h400 + 32'(i * 4);
      cyc();
    end
    exp_rd(32'h300);
    exp_w(32'h310, 32'h55, 4'h1);
    exp_w(32'h314, 32'h66, 4'h1);
    s1_rd = 1'b1; s1_raddr = 32'h300;
    cyc();
    chk("t5_full_1", 64'(s1_full), 64'd0);
    s1_wr = 1'b1; s1_waddr = 32'h310; s1_wdata = 32'h55; s1_wstrb = 4'h1;
    cyc();
    chk("t5_full_2", 64'(s1_full), 64'd0);
`ifdef AXI_CONFIG_ARB_ERR_EN
    chk("t5_err_clear", 64'(err), 64'd0);
`endif
    s1_wr = 1'b1; s1_waddr = 32'h314; s1_wdata = 32'h66; s1_wstrb = 4'h1;
    cyc();
    chk("t5_full_3", 64'(s1_full), 64'd1);
    s1_wr = 1'b1; s1_waddr = 32'h318; s1_wdata = 32'h77; s1_wstrb = 4'h1;
    cyc();
    chk("t5_full_hold", 64'(s1_full), 64'd1);
`ifdef AXI_CONFIG_ARB_ERR_EN
    chk("t5_err_drop", 64'(err), 64'b01);
`endif
    for (int i = 0; i < 4; i++) begin
      exp_r0.push_back(32'hC0 + 32'(i));
      m_rvalid = 1'b1; m_rdata = 32'hC0 + 32'(i);
      cyc();
    end
    idle(3);
    exp_r1.push_back(32'hC4);
    m_rvalid = 1'b1; m_rdata = 32'hC4;
    cyc();
    chk("t5_s1_return", 64'({s1_rvalid, s1_rdata}), {31'd0, 1'b1, 32'hC4});
    idle(2);
    chk("t5_full_drained", 64'(s1_full), 64'd0);

    // Reset with two reads outstanding: late responses are orphans.
    exp_rd(32'h500);
    exp_rd(32'h504);
    s0_rd = 1'b1; s0_raddr = 32'h500;
    cyc();
    s0_rd = 1'b1; s0_raddr = 32'h504;
    cyc();
    idle(1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk_reset_state("midreset");
    m_rvalid = 1'b1; m_rdata = 32'hEE;
    cyc();
    chk("t6_orphan_1", 64'({s1_rvalid, s0_rvalid}), 64'd0);
    m_rvalid = 1'b1; m_rdata = 32'hEF;
    cyc();
    chk("t6_orphan_2", 64'({s1_rvalid, s0_rvalid}), 64'd0);
    chk("t6_rdata_kept", 64'(s0_rdata), 64'd0);
`ifdef AXI_CONFIG_ARB_ERR_EN
    chk("t6_err_orphan", 64'(err), 64'b10);
`endif
    idle(3);

    chk("end_cmd_queue", 64'(exp_cmd.size()), 64'd0);
    chk("end_r0_queue", 64'(exp_r0.size()), 64'd0);
    chk("end_r1_queue", 64'(exp_r1.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
